mem_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the CPU's single 16-bit memory/IO bus between REQ_COUNT requesters (requester 0 = cpu core; others = port/peripheral masters).
- Accepts one request at a time and drives the shared bus strobes until the memory side acknowledges.
- Returns read data to the granted requester.
- Sits between the cpu core and the memory/port decode logic.

---
 rtl/arb_pkg.sv | 19 +
 rtl/mem_bus_arbiter_rr_picker.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory bus arbiter: FSM state encoding,
// default bus widths and the round-robin pointer width.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // A pointer over n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the first valid requester found
// searching upward from rr_ptr (wrapping) wins.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        index      = idx;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory/IO bus between REQ_COUNT requesters.
// Define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles without ack.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int REQ_COUNT      = 2,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_COUNT-1:0]        req_valid,
  input  logic [REQ_COUNT-1:0]        req_write,
  input  logic [REQ_COUNT*ADDR_W-1:0] req_addr,
  input  logic [REQ_COUNT*DATA_W-1:0] req_wdata,
  output logic [REQ_COUNT-1:0]        req_ready,
  output logic [REQ_COUNT-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic                        busy
);

  localparam int PW = ptr_width(REQ_COUNT);

  arb_state_t           state_reg, state_next;
  logic [PW-1:0]        rr_ptr_reg, grant_reg, pick_idx, ptr_next;
  logic [REQ_COUNT-1:0] pick_grant;
  logic                 pick_any;
  logic                 write_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg, rdata_reg;
  logic                 accept, done, timeout_hit;

  rr_picker #(.N(REQ_COUNT), .PW(PW)) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_reg),
    .grant  (pick_grant),
    .index  (pick_idx),
    .any    (pick_any)
  );

  assign accept   = (state_reg == IDLE) && pick_any;
  assign done     = (state_reg == BUSY) && (mem_ack || timeout_hit);
  assign ptr_next = (pick_idx == PW'(REQ_COUNT - 1)) ? '0 : pick_idx + PW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          err_reg;

  // The last BUSY cycle before the limit decides; a same-cycle ack still wins.
  assign timeout_hit = (state_reg == BUSY) && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (accept)
        tmo_cnt_reg <= '0;
      else if (state_reg == BUSY && !mem_ack)
        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (done)
        err_reg <= !mem_ack;
    end
  end

  assign rsp_err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE: req_ready = pick_grant;
      BUSY: begin
        mem_read  = !write_reg;
        mem_write = write_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      if (accept) begin
        rr_ptr_reg <= ptr_next;
        grant_reg  <= pick_idx;
        write_reg  <= req_write[pick_idx];
        addr_reg   <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        wdata_reg  <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
      end
      // Writes and timeouts return zero data.
      if (done)
        rdata_reg <= (mem_ack && !write_reg) ? mem_rdata : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REQ_COUNT; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == PW'(gi));
    end
  endgenerate

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks plus a response
// scoreboard fed at acceptance time and drained when rsp_valid pulses.
module tb_mem_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            rsp_err, mem_read, mem_write, mem_ack, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ptr = 0;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  mem_bus_arbiter #(
    .REQ_COUNT(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_model(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] oh;
    oh = '0;
    if (i >= 0) oh[i] = 1'b1;
    return oh;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b, required no response", rsp_valid);
      end else begin
        e = sb_q.pop_front();
        if (rsp_valid !== onehot(e.idx)) begin
          errors++;
          $display("FAIL sb_rsp_valid: got %b, expected %b", rsp_valid, onehot(e.idx));
        end
        checks++;
        if (rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_rsp_rdata: got %h, expected %h", rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL sb_rsp_err: got %b, expected %b", rsp_err, e.err);
        end
      end
      $display("rsp cycle %0d: valid=%b rdata=%h err=%b", cyc, rsp_valid, rsp_rdata, rsp_err);
    end
  end

  task automatic test_reset();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({busy, mem_read, mem_write, rsp_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/rd/wr/err=%b, expected 0000", {busy, mem_read, mem_write, rsp_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, expected 0", mem_addr, mem_wdata, rsp_rdata);
    end
    checks++;
    if ({rsp_valid, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_handshake: rsp_valid=%b req_ready=%b, expected 0", rsp_valid, req_ready);
    end
    tick();
    rst = 1'b0;
    exp_ptr = 0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_single_read();
    int w;
    req_valid = 2'b01; req_write = 2'b00; req_addr = {16'h0000, 16'h0010};
    @(negedge clk);
    w = rr_model(req_valid, exp_ptr);
    checks++;
    if (req_ready !== onehot(w)) begin
      errors++;
      $display("FAIL read_ready: got %b, expected %b", req_ready, onehot(w));
    end
    sb_q.push_back('{idx: w, rdata: 16'h00AA, err: 1'b0});
    exp_ptr = (w + 1) % N;
    tick();
    req_valid = '0; mem_ack = 1'b1; mem_rdata = 16'h00AA;
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, busy, req_ready} !== 5'b10100 || mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL read_strobe: rd=%b wr=%b busy=%b ready=%b addr=%h, expected 1 0 1 00 0010",
               mem_read, mem_write, busy, req_ready, mem_addr);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL read_resp_timing: rsp_valid=%b rd=%b, expected 01 0", rsp_valid, mem_read);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_rdata !== 16'h00AA) begin
      errors++;
      $display("FAIL read_after: busy=%b rsp_valid=%b rdata=%h, expected 0 00 00aa", busy, rsp_valid, rsp_rdata);
    end
    $display("single read done at cycle %0d", cyc);
    tick();
  endtask

  task automatic test_alternate();
    int w, last_acc;
    last_acc = 0;
    req_valid = 2'b11; req_write = 2'b00; req_addr = {16'h0101, 16'h0100};
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      w = rr_model(req_valid, exp_ptr);
      checks++;
      if (req_ready !== onehot(w)) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b, expected %b", n, req_ready, onehot(w));
      end
      if (n > 0) begin
        checks++;
        if (cyc - last_acc != 3) begin
          errors++;
          $display("FAIL alt_spacing[%0d]: got %0d cycles, expected 3", n, cyc - last_acc);
        end
      end
      last_acc = cyc;
      sb_q.push_back('{idx: w, rdata: 16'hA000 + 16'(n), err: 1'b0});
      exp_ptr = (w + 1) % N;
      $display("alt txn %0d: grant %0d at cycle %0d", n, w, cyc);
      tick();
      mem_ack = 1'b1; mem_rdata = 16'hA000 + 16'(n);
      @(negedge clk);
      checks++;
      if (mem_addr !== ((w == 1) ? 16'h0101 : 16'h0100)) begin
        errors++;
        $display("FAIL alt_addr[%0d]: got %h, expected %h", n, mem_addr, (w == 1) ? 16'h0101 : 16'h0100);
      end
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_write_delayed();
    req_valid = 2'b10; req_write = 2'b10;
    req_addr = {16'h0200, 16'h0000}; req_wdata = {16'hBEEF, 16'h0000};
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b, expected 10", req_ready);
    end
    sb_q.push_back('{idx: 1, rdata: 16'h0000, err: 1'b0});
    exp_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_valid = '0; mem_ack = (i == 4); mem_rdata = 16'hDEAD;
      @(negedge clk);
      checks++;
      if ({mem_write, mem_read} !== 2'b10 || mem_addr !== 16'h0200 || mem_wdata !== 16'hBEEF) begin
        errors++;
        $display("FAIL wr_busy[%0d]: wr=%b rd=%b addr=%h wdata=%h, expected 1 0 0200 beef",
                 i, mem_write, mem_read, mem_addr, mem_wdata);
      end
    end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp: rsp_valid=%b wr=%b, expected 10 0", rsp_valid, mem_write);
    end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL wr_after: busy=%b rdata=%h, expected 0 0000", busy, rsp_rdata);
    end
    $display("delayed write done at cycle %0d", cyc);
    tick();
  endtask

  task automatic test_reset_abort();
    req_valid = 2'b01; req_write = 2'b00; req_addr = {16'h0000, 16'h0030};
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL abort_ready: got %b, expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: rd=%b, expected 1", mem_read);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_read, mem_write, busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_async: rd/wr/busy=%b, expected 000", {mem_read, mem_write, busy});
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_rsp: rsp_valid=%b, expected 00", rsp_valid);
    end
    tick();
    rst = 1'b0;
    exp_ptr = 0;
    req_valid = 2'b11; req_addr = {16'h0041, 16'h0040};
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(rr_model(req_valid, exp_ptr))) begin
      errors++;
      $display("FAIL abort_tie: got %b, expected %b", req_ready, onehot(rr_model(req_valid, exp_ptr)));
    end
    sb_q.push_back('{idx: 0, rdata: 16'h0C0C, err: 1'b0});
    exp_ptr = 1;
    tick();
    req_valid = '0; mem_ack = 1'b1; mem_rdata = 16'h0C0C;
    @(negedge clk);
    checks++;
    if (mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL abort_addr: got %h, expected 0040", mem_addr);
    end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    $display("reset abort recovered at cycle %0d", cyc);
    tick();
  endtask

  task automatic test_stray_ack();
    int w;
    req_valid = '0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_read, mem_write} !== 3'b000 || rsp_valid !== 2'b00 || rsp_rdata !== 16'h0C0C) begin
        errors++;
        $display("FAIL stray_ack[%0d]: busy/rd/wr=%b rsp_valid=%b rdata=%h, expected 000 00 0c0c",
                 i, {busy, mem_read, mem_write}, rsp_valid, rsp_rdata);
      end
      tick();
    end
    mem_ack = 1'b0;
    req_valid = 2'b11; req_addr = {16'h0051, 16'h0050};
    @(negedge clk);
    w = rr_model(req_valid, exp_ptr);
    checks++;
    if (req_ready !== onehot(w)) begin
      errors++;
      $display("FAIL stray_ptr_kept: got %b, expected %b", req_ready, onehot(w));
    end
    sb_q.push_back('{idx: w, rdata: 16'h7777, err: 1'b0});
    exp_ptr = (w + 1) % N;
    tick();
    req_valid = '0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    checks++;
    if (mem_addr !== ((w == 1) ? 16'h0051 : 16'h0050)) begin
      errors++;
      $display("FAIL stray_addr: got %h, expected %h", mem_addr, (w == 1) ? 16'h0051 : 16'h0050);
    end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    $display("stray ack test done at cycle %0d", cyc);
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int t = 0; t < 2; t++) begin
      req_valid = 2'b01; req_write = 2'b00; req_addr = {16'h0000, 16'h0060};
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("FAIL tmo_ready[%0d]: got %b, expected 01", t, req_ready);
      end
      if (t == 0) sb_q.push_back('{idx: 0, rdata: 16'h0000, err: 1'b1});
      else        sb_q.push_back('{idx: 0, rdata: 16'h5555, err: 1'b0});
      exp_ptr = 1;
      for (int i = 0; i < 4; i++) begin
        tick();
        req_valid = '0;
        mem_ack = (t == 1) && (i == 3);
        mem_rdata = (t == 1) ? 16'h5555 : 16'h9999;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
          errors++;
          $display("FAIL tmo_busy[%0d.%0d]: rd=%b, expected 1", t, i, mem_read);
        end
      end
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL tmo_resp[%0d]: rsp_valid=%b rd=%b, expected 01 0", t, rsp_valid, mem_read);
      end
      $display("timeout txn %0d done at cycle %0d", t, cyc);
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_write_delayed();
    test_reset_abort();
    test_stray_ack();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d responses missing, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
